// File: rtl/pwm_channel_bank.sv
// pwm_channel_bank: NUM_CH PWM channels sharing one prescaled counter.
// Define PWM_SHADOW_EN to double-buffer presc/top/duty until the wrap.
`timescale 1ns/1ps
module pwm_channel_bank #(
    parameter int unsigned NUM_CH  = 8,
    parameter logic [7:0]  RST_TOP = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [6:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [6:0] ADDR_OUT_EN = 7'h00;
    localparam logic [6:0] ADDR_MODE   = 7'h01;
    localparam logic [6:0] ADDR_PRESC  = 7'h02;
    localparam logic [6:0] ADDR_TOP    = 7'h03;
    localparam logic [6:0] ADDR_DUTY   = 7'h10;

    logic              wr_out_en;
    logic              wr_mode;
    logic              wr_presc;
    logic              wr_top;
    logic [NUM_CH-1:0] wr_duty;

    logic [NUM_CH-1:0] out_en;
    logic [NUM_CH-1:0] pwm_mode;
    logic [7:0]        presc_act;
    logic [7:0]        top_act;
    logic [7:0]        duty_act [NUM_CH];
    logic [7:0]        pre_cnt;
    logic [7:0]        cnt;

    logic              tick;
    logic              wrap;
    logic [NUM_CH-1:0] pwm_next;

    assign wr_out_en = wr_en && (wr_addr == ADDR_OUT_EN);
    assign wr_mode   = wr_en && (wr_addr == ADDR_MODE);
    assign wr_presc  = wr_en && (wr_addr == ADDR_PRESC);
    assign wr_top    = wr_en && (wr_addr == ADDR_TOP);

    // Only implemented channels decode, so writes to higher indices drop.
    always_comb begin
        wr_duty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_duty[i] = wr_en && (wr_addr == ADDR_DUTY + 7'(i));
        end
    end

    assign tick = (pre_cnt == presc_act);

`ifdef PWM_SHADOW_EN
    assign wrap = tick && (cnt == top_act);
`else
    assign wrap = tick && (cnt >= top_act);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en   <= '0;
            pwm_mode <= '0;
        end else begin
            if (wr_out_en) begin
                out_en <= wr_data[NUM_CH-1:0];
            end
            if (wr_mode) begin
                pwm_mode <= wr_data[NUM_CH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            cnt     <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            cnt     <= wrap ? 8'd0 : cnt + 8'd1;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

`ifdef PWM_SHADOW_EN
    logic [7:0] presc_sh;
    logic [7:0] top_sh;
    logic [7:0] duty_sh [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_sh <= '0;
            top_sh   <= RST_TOP;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh[i] <= '0;
            end
        end else begin
            if (wr_presc) begin
                presc_sh <= wr_data;
            end
            if (wr_top) begin
                top_sh <= wr_data;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_duty[i]) begin
                    duty_sh[i] <= wr_data;
                end
            end
        end
    end

    // Wrap sees the pre-edge shadow, so a coincident write waits a period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_act <= '0;
            top_act   <= RST_TOP;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act[i] <= '0;
            end
        end else if (wrap) begin
            presc_act <= presc_sh;
            top_act   <= top_sh;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act[i] <= duty_sh[i];
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_act <= '0;
            top_act   <= RST_TOP;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act[i] <= '0;
            end
        end else begin
            if (wr_presc) begin
                presc_act <= wr_data;
            end
            if (wr_top) begin
                top_act <= wr_data;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_duty[i]) begin
                    duty_act[i] <= wr_data;
                end
            end
        end
    end
`endif

    always_comb begin
        pwm_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_next[i] = out_en[i]
                        & (pwm_mode[i] ? (cnt < duty_act[i]) : 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else begin
            pwm_out     <= pwm_next;
            period_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Self-checking bench for pwm_channel_bank (default NUM_CH=8, RST_TOP=FF).
// Build with or without PWM_SHADOW_EN to match the RTL build.
`timescale 1ns/1ps
module tb_pwm_channel_bank;

    localparam int NCH = 8;

    logic           clk     = 1'b0;
    logic           clk_run = 1'b0;
    logic           rst_n   = 1'b1;
    logic           wr_en   = 1'b0;
    logic [6:0]     wr_addr = '0;
    logic [7:0]     wr_data = '0;
    logic [NCH-1:0] pwm_out;
    logic           period_tick;

    int n_pass  = 0;
    int n_total = 0;

    pwm_channel_bank #(
        .NUM_CH (NCH),
        .RST_TOP(8'hFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Behavioural model: register file plus integer counters.
    int             m_en, m_mode, m_pre, m_cnt;
    int             m_presc, m_top, m_presc_sh, m_top_sh;
    int             m_duty [NCH];
    int             m_duty_sh [NCH];
    logic [NCH-1:0] m_out;
    logic           m_tick;

    function automatic void model_reset();
        m_en = 0; m_mode = 0; m_pre = 0; m_cnt = 0;
        m_presc = 0; m_presc_sh = 0;
        m_top = 255; m_top_sh = 255;
        for (int i = 0; i < NCH; i++) begin
            m_duty[i] = 0;
            m_duty_sh[i] = 0;
        end
        m_out = '0;
        m_tick = 1'b0;
    endfunction

    function automatic void model_step(input bit we, input int a, input int d);
        bit tk, wrp;
        bit on;
        tk = (m_pre == m_presc);
`ifdef PWM_SHADOW_EN
        wrp = tk && (m_cnt == m_top);
`else
        wrp = tk && (m_cnt >= m_top);
`endif
        for (int i = 0; i < NCH; i++) begin
            on = ((m_mode >> i) & 1) == 0 || m_cnt < m_duty[i];
            m_out[i] = (((m_en >> i) & 1) == 1) && on;
        end
        m_tick = wrp;
        if (tk) begin
            m_pre = 0;
            m_cnt = wrp ? 0 : (m_cnt + 1) % 256;
        end else begin
            m_pre = (m_pre + 1) % 256;
        end
`ifdef PWM_SHADOW_EN
        if (wrp) begin
            m_presc = m_presc_sh;
            m_top = m_top_sh;
            for (int i = 0; i < NCH; i++) m_duty[i] = m_duty_sh[i];
        end
`endif
        if (we) begin
            if (a == 0) m_en = d;
            else if (a == 1) m_mode = d;
`ifdef PWM_SHADOW_EN
            else if (a == 2) m_presc_sh = d;
            else if (a == 3) m_top_sh = d;
            else if (a >= 16 && a < 16 + NCH) m_duty_sh[a - 16] = d;
`else
            else if (a == 2) m_presc = d;
            else if (a == 3) m_top = d;
            else if (a >= 16 && a < 16 + NCH) m_duty[a - 16] = d;
`endif
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(wr_en, int'(wr_addr), int'(wr_data));
    end

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic sync_tick(input int limit, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            ok = (period_tick === 1'b1);
        end
    endtask

    // Starts on a tick sample; counts samples up to and including the next.
    task automatic measure_period(input int ch, input int wr_at,
                                  input logic [6:0] a, input logic [7:0] d,
                                  output int len, output int highs);
        len = 0;
        highs = 0;
        do begin
            if (len == wr_at) begin
                wr_en = 1'b1;
                wr_addr = a;
                wr_data = d;
            end
            @(negedge clk);
            wr_en = 1'b0;
            len++;
            if (pwm_out[ch] === 1'b1) highs++;
        end while (period_tick !== 1'b1 && len < 2000);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #20;
        n_total++;
        if (pwm_out !== '0) $display("FAIL reset_out: got %h need 00", pwm_out);
        else n_pass++;
        n_total++;
        if (period_tick !== 1'b0) $display("FAIL reset_tick: got %b need 0", period_tick);
        else n_pass++;
        rst_n = 1'b1;
        #2 clk_run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++;
            if (pwm_out !== '0 || period_tick !== 1'b0)
                $display("FAIL post_reset: cyc %0d got %h/%b need 00/0", i, pwm_out, period_tick);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        bit ok;
        int len, highs;
        do_write(7'h02, 8'd0);
        do_write(7'h03, 8'd9);
        do_write(7'h10, 8'd3);
        do_write(7'h01, 8'h01);
        do_write(7'h00, 8'h01);
        sync_tick(600, ok);
        n_total++;
        if (!ok) $display("FAIL basic_sync: no period_tick within 600 cycles");
        else n_pass++;
        for (int p = 0; p < 3; p++) begin
            measure_period(0, -1, 7'h00, 8'h00, len, highs);
            n_total++;
            if (len !== 10) $display("FAIL basic_len: got %0d need 10", len);
            else n_pass++;
            n_total++;
            if (highs !== 3) $display("FAIL basic_high: got %0d need 3", highs);
            else n_pass++;
        end
    endtask

    task automatic test_prescaler();
        bit ok;
        int len, highs;
        do_write(7'h02, 8'd3);
        do_write(7'h03, 8'd4);
        do_write(7'h11, 8'd2);
        do_write(7'h01, 8'h03);
        do_write(7'h00, 8'h03);
        sync_tick(600, ok);
        n_total++;
        if (!ok) $display("FAIL presc_sync: no period_tick within 600 cycles");
        else n_pass++;
        for (int p = 0; p < 2; p++) begin
            measure_period(1, -1, 7'h00, 8'h00, len, highs);
            n_total++;
            if (len !== 20) $display("FAIL presc_len: got %0d need 20", len);
            else n_pass++;
            n_total++;
            if (highs !== 8) $display("FAIL presc_high: got %0d need 8", highs);
            else n_pass++;
        end
    endtask

    task automatic test_extremes();
        bit ok;
        int len, highs;
        do_write(7'h02, 8'd0);
        do_write(7'h03, 8'd9);
        do_write(7'h12, 8'd0);
        do_write(7'h13, 8'd10);
        do_write(7'h01, 8'h0F);
        do_write(7'h00, 8'h0F);
        sync_tick(1000, ok);
        n_total++;
        if (!ok) $display("FAIL ext_sync: no period_tick within 1000 cycles");
        else n_pass++;
        measure_period(2, -1, 7'h00, 8'h00, len, highs);
        n_total++;
        if (len !== 10 || highs !== 0)
            $display("FAIL duty_zero: got len %0d high %0d need 10/0", len, highs);
        else n_pass++;
        measure_period(3, -1, 7'h00, 8'h00, len, highs);
        n_total++;
        if (len !== 10 || highs !== 10)
            $display("FAIL duty_over_top: got len %0d high %0d need 10/10", len, highs);
        else n_pass++;
        do_write(7'h01, 8'h00);
        do_write(7'h00, 8'h05);
        n_total++;
        if (pwm_out !== 8'h0F) $display("FAIL static_latency: got %h need 0f", pwm_out);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (pwm_out !== 8'h05) $display("FAIL static_out: got %h need 05", pwm_out);
        else n_pass++;
    endtask

    task automatic test_shadow();
        bit ok;
        int len, highs;
        int exp_h [4];
        int wr_at [4];
        logic [7:0] wd [4];
`ifdef PWM_SHADOW_EN
        exp_h = '{3, 3, 7, 5};
`else
        exp_h = '{3, 7, 5, 5};
`endif
        wr_at = '{9, -1, 4, -1};
        wd = '{8'd7, 8'd0, 8'd5, 8'd0};
        do_write(7'h01, 8'h01);
        do_write(7'h00, 8'h01);
        sync_tick(600, ok);
        n_total++;
        if (!ok) $display("FAIL shadow_sync: no period_tick within 600 cycles");
        else n_pass++;
        for (int p = 0; p < 4; p++) begin
            measure_period(0, wr_at[p], 7'h10, wd[p], len, highs);
            n_total++;
            if (len !== 10 || highs !== exp_h[p])
                $display("FAIL shadow_p%0d: got len %0d high %0d need 10/%0d",
                         p, len, highs, exp_h[p]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int len, highs;
        do_write(7'h01, 8'h00);
        do_write(7'h00, 8'h01);
        @(negedge clk);
        n_total++;
        if (pwm_out !== 8'h01) $display("FAIL pre_reset: got %h need 01", pwm_out);
        else n_pass++;
        #2 rst_n = 1'b0;
        #0.5;
        n_total++;
        if (pwm_out !== '0 || period_tick !== 1'b0)
            $display("FAIL async_reset: got %h/%b need 00/0", pwm_out, period_tick);
        else n_pass++;
        #0.5 rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (pwm_out !== '0) $display("FAIL after_reset: got %h need 00", pwm_out);
        else n_pass++;
        do_write(7'h10, 8'd128);
        do_write(7'h01, 8'h01);
        do_write(7'h00, 8'h01);
        sync_tick(600, ok);
        n_total++;
        if (!ok) $display("FAIL rst_sync: no period_tick within 600 cycles");
        else n_pass++;
        measure_period(0, -1, 7'h00, 8'h00, len, highs);
        n_total++;
        if (len !== 256 || highs !== 128)
            $display("FAIL rst_top: got len %0d high %0d need 256/128", len, highs);
        else n_pass++;
    endtask

    task automatic test_random();
        int sel;
        for (int c = 0; c < 2500; c++) begin
            n_total++;
            if (pwm_out !== m_out)
                $display("FAIL rand_out: cyc %0d got %h need %h", c, pwm_out, m_out);
            else n_pass++;
            n_total++;
            if (period_tick !== m_tick)
                $display("FAIL rand_tick: cyc %0d got %b need %b", c, period_tick, m_tick);
            else n_pass++;
            wr_en = 1'b0;
            if ($urandom_range(3) == 0) begin
                wr_en = 1'b1;
                sel = int'($urandom_range(5));
                case (sel)
                    0: begin wr_addr = 7'h00; wr_data = 8'($urandom); end
                    1: begin wr_addr = 7'h01; wr_data = 8'($urandom); end
                    2: begin wr_addr = 7'h02; wr_data = 8'($urandom_range(3)); end
                    3: begin wr_addr = 7'h03; wr_data = 8'($urandom_range(31)); end
                    4: begin
                        wr_addr = 7'(8'h10 + 8'($urandom_range(7)));
                        wr_data = 8'($urandom_range(40));
                    end
                    default: begin
                        wr_addr = 7'(8'h04 + 8'($urandom_range(11)));
                        if ($urandom_range(1) == 1)
                            wr_addr = 7'(8'h18 + 8'($urandom_range(103)));
                        wr_data = 8'($urandom);
                    end
                endcase
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescaler();
        test_extremes();
        test_shadow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pwm_channel_bank.md
# pwm_channel_bank

Register-programmed multi-channel PWM generator that sits behind the SPI peripheral in the user project and drives `uo_out`. It generalises the single fixed-frequency PWM output to `NUM_CH` channels. All channels share one counter with a programmable prescaler and period. Each channel has its own duty, enable and mode, and period/duty updates are double-buffered so they are glitch-free.

## Interface
- `NUM_CH`, default 8: number of channels, legal range 1..8.
- `RST_TOP`, default 8'hFF: reset value of the period (TOP) register.
- `clk  in  1`: single system clock; all state updates on the rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `wr_en  in  1`: one-cycle write strobe from the SPI peripheral.
- `wr_addr  in  7`: register address.
- `wr_data  in  8`: register write data.
- `pwm_out  out  NUM_CH`: registered channel outputs.
- `period_tick  out  1`: registered one-cycle pulse at each counter wrap.

## Operation
- Register map. Writes to unmapped addresses are ignored, and so are writes to channel indices >= `NUM_CH`.
  - 0x00 `out_en[NUM_CH-1:0]`; bits above `NUM_CH` are discarded.
  - 0x01 `pwm_mode[NUM_CH-1:0]`.
  - 0x02 `presc` (8 b).
  - 0x03 `top` (8 b).
  - 0x10+i `duty[i]` (8 b).
- Reset values:
  - `out_en`, `pwm_mode`, `presc` and all duty = 0.
  - `top` = `RST_TOP`.
  - Internal counters `pre_cnt` and `cnt` = 0.
  - `pwm_out` = 0 and `period_tick` = 0.
- Prescaler: `pre_cnt` counts 0..`presc_act`. The tick is asserted when `pre_cnt == presc_act`, and `pre_cnt` then returns to 0. With `presc_act` = 0 the tick fires every cycle.
- Main counter, on each tick:
  - If `cnt == top_act`, set `cnt` to 0; this is the wrap.
  - Otherwise increment `cnt` by 1.
- Period = (`top_act`+1)*(`presc_act`+1) cycles.
- Shadowing:
  - Writes to 0x02, 0x03 and 0x10+i land in shadow registers.
  - `presc_act`, `top_act` and `duty_act[i]` load from the shadows on the wrap edge only.
  - `out_en` and `pwm_mode` are not shadowed.
- Channel output, registered:
  - `pwm_out[i]` <= `out_en[i]` & (`pwm_mode[i]` ? (`cnt` < `duty_act[i]`) : 1).
  - Comparison is unsigned, 8-bit.
  - `duty` = 0 gives constant low.
  - `duty` > `top_act` gives constant high.
- `period_tick` is asserted for exactly one cycle following each wrap edge.

## Timing
- A write strobe at edge e updates the target register at e.
- `out_en`/`pwm_mode` changes are visible on `pwm_out` after edge e+1 (one cycle of latency).
- `pwm_out` at edge k+1 reflects `cnt` and `duty_act` as they stood after edge k.
- Write coincident with wrap: the wrap loads the old shadow value. The new write takes effect at the following wrap.
- Write of `top` below the current `cnt` (shadowed): has no effect until the wrap, because the wrap uses `top_act`.
- Reset asserted mid-period: all state returns to its reset value immediately, without waiting for a clock. After release the counter restarts from 0.
- Back-to-back writes on consecutive cycles are all accepted. The last write before a wrap wins.

## Configuration
- `PWM_SHADOW_EN` defined: shadowing is active, as described above.
- Not defined: writes to `presc`, `top` and `duty[i]` update the active registers directly at edge e. The `cnt == top_act` wrap compare becomes `cnt >= top_act`, so that lowering `top` below `cnt` wraps on the next tick instead of running to 255.
- All other behaviour is identical in both builds.

## Test plan
- Reset check. Hold `rst_n`=0 and apply no clocks. Release and run 10 cycles. Required: `pwm_out`=0 and `period_tick`=0 throughout.
- Basic PWM. `presc`=0, `top`=9, `duty[0]`=3, `pwm_mode`=0x01, `out_en`=0x01, all written before the first wrap takes them. Required: after the first wrap, `pwm_out[0]` is high 3 cycles of every 10, and `period_tick` pulses every 10 cycles.
- Prescaler. `presc`=3, `top`=4, `duty[1]`=2, channel 1 enabled in PWM mode. Required: period 20 cycles, high 8 cycles, `period_tick` spacing 20.
- Extremes and static mode, with `top`=9:
  - `duty[2]`=0: constant low.
  - `duty[3]`=10: constant high.
  - `out_en`=0x05 with `pwm_mode`=0: `pwm_out`=0x05 one cycle after the register update.
- Shadow update. Change `duty[0]` from 3 to 7 mid-period, including a write on the exact wrap cycle. Required: the old duty holds until the wrap after the write. Without `PWM_SHADOW_EN` the change applies on the next cycle.
- Reset mid-operation. Pulse `rst_n` low for 1 ns while `pwm_out`=0x01. Required: outputs drop asynchronously, and `top` reads back as 0xFF behaviour (period 256).
